// File: rtl/wb_commit_unit.sv
// MEM/WB commit stage: selects writeback data and drives the integer/FP register-file write ports.
// Double-word results are split into an even/odd register pair over two cycles, stalling upstream for the odd write.
module wb_commit_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iWrite,
  input  logic              iFloat,
  input  logic [1:0]        iWBsrc,
  input  logic              iDW,
  input  logic [DATA_W-1:0] iALUout1,
  input  logic [DATA_W-1:0] iALUout2,
  input  logic [DATA_W-1:0] iMemOut1,
  input  logic [DATA_W-1:0] iMemOut2,
  input  logic [DATA_W-1:0] iPcp4,
  input  logic [DATA_W-1:0] iIm,
  input  logic [REG_AW-1:0] iDstReg,
  output logic              oIntWe,
  output logic [REG_AW-1:0] oIntAddr,
  output logic [DATA_W-1:0] oIntData,
  output logic              oFpWe,
  output logic [REG_AW-1:0] oFpAddr,
  output logic [DATA_W-1:0] oFpData,
  output logic              oStall
);

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t            state, stateNext;
  logic [REG_AW-1:0] secAddr, secAddrNext;
  logic [DATA_W-1:0] secData, secDataNext;
  logic              secFloat, secFloatNext;
  logic              intWeNext, fpWeNext;
  logic [REG_AW-1:0] intAddrNext, fpAddrNext;
  logic [DATA_W-1:0] intDataNext, fpDataNext;
  logic [DATA_W-1:0] word1, word2;
  logic [REG_AW-1:0] firstAddr;

  // First-word source mux; the high word only ever comes from memory or the ALU.
  always_comb begin
    word1 = iALUout1;
    case (iWBsrc)
      2'd0: word1 = iALUout1;
      2'd1: word1 = iMemOut1;
      2'd2: word1 = iPcp4;
      2'd3: word1 = iIm;
      default: word1 = iALUout1;
    endcase
  end

  assign word2     = (iWBsrc == 2'd1) ? iMemOut2 : iALUout2;
  assign firstAddr = iDW ? {iDstReg[REG_AW-1:1], 1'b0} : iDstReg;
  assign oStall    = (state == SECOND);

  // Next-state and next write-port values; address/data hold when no write is issued.
  always_comb begin
    stateNext    = state;
    secAddrNext  = secAddr;
    secDataNext  = secData;
    secFloatNext = secFloat;
    intWeNext    = 1'b0;
    fpWeNext     = 1'b0;
    intAddrNext  = oIntAddr;
    intDataNext  = oIntData;
    fpAddrNext   = oFpAddr;
    fpDataNext   = oFpData;
    unique case (state)
      IDLE: begin
        if (iWrite) begin
          if (iFloat) begin
            fpWeNext   = 1'b1;
            fpAddrNext = firstAddr;
            fpDataNext = word1;
          end else begin
            intWeNext   = (firstAddr != '0);
            intAddrNext = firstAddr;
            intDataNext = word1;
          end
          if (iDW) begin
            secAddrNext  = {iDstReg[REG_AW-1:1], 1'b1};
            secDataNext  = word2;
            secFloatNext = iFloat;
            stateNext    = SECOND;
          end
        end
      end
      SECOND: begin
        if (secFloat) begin
          fpWeNext   = 1'b1;
          fpAddrNext = secAddr;
          fpDataNext = secData;
        end else begin
          intWeNext   = (secAddr != '0);
          intAddrNext = secAddr;
          intDataNext = secData;
        end
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      secAddr  <= '0;
      secData  <= '0;
      secFloat <= 1'b0;
      oIntWe   <= 1'b0;
      oIntAddr <= '0;
      oIntData <= '0;
      oFpWe    <= 1'b0;
      oFpAddr  <= '0;
      oFpData  <= '0;
    end else begin
      state    <= stateNext;
      secAddr  <= secAddrNext;
      secData  <= secDataNext;
      secFloat <= secFloatNext;
      oIntWe   <= intWeNext;
      oIntAddr <= intAddrNext;
      oIntData <= intDataNext;
      oFpWe    <= fpWeNext;
      oFpAddr  <= fpAddrNext;
      oFpData  <= fpDataNext;
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: a reference model queues per-cycle expected write-port
// activity for every issued instruction, and a negedge monitor pops and compares each cycle.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iWrite = 1'b0, iFloat = 1'b0, iDW = 1'b0;
  logic [1:0]  iWBsrc = '0;
  logic [31:0] iALUout1 = '0, iALUout2 = '0, iMemOut1 = '0, iMemOut2 = '0, iPcp4 = '0, iIm = '0;
  logic [4:0]  iDstReg = '0;
  logic        oIntWe, oFpWe, oStall;
  logic [4:0]  oIntAddr, oFpAddr;
  logic [31:0] oIntData, oFpData;

  wb_commit_unit #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .iWrite(iWrite), .iFloat(iFloat), .iWBsrc(iWBsrc), .iDW(iDW),
    .iALUout1(iALUout1), .iALUout2(iALUout2), .iMemOut1(iMemOut1), .iMemOut2(iMemOut2),
    .iPcp4(iPcp4), .iIm(iIm), .iDstReg(iDstReg),
    .oIntWe(oIntWe), .oIntAddr(oIntAddr), .oIntData(oIntData),
    .oFpWe(oFpWe), .oFpAddr(oFpAddr), .oFpData(oFpData), .oStall(oStall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, fl, dw;
    logic [1:0]  src;
    logic [31:0] a1, a2, m1, m2, pc, im;
    logic [4:0]  dst;
  } instr_t;

  typedef struct {
    logic        hasPort, isFp, we, stall;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic monOn = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue entry per clock cycle the instruction occupies the write ports.
  task automatic model(input instr_t t);
    exp_t e;
    logic [31:0] w1, w2;
    int base;
    e = '{hasPort: 1'b0, isFp: 1'b0, we: 1'b0, stall: 1'b0, addr: '0, data: '0};
    if (!t.wr) begin
      q.push_back(e);
      return;
    end
    case (t.src)
      2'd0: w1 = t.a1;
      2'd1: w1 = t.m1;
      2'd2: w1 = t.pc;
      default: w1 = t.im;
    endcase
    w2 = (t.src == 2'd1) ? t.m2 : t.a2;
    if (!t.dw) begin
      e = '{hasPort: 1'b1, isFp: t.fl, we: t.fl || (t.dst != 0), stall: 1'b0, addr: t.dst, data: w1};
      q.push_back(e);
    end else begin
      base = (int'(t.dst) / 2) * 2;
      e = '{hasPort: 1'b1, isFp: t.fl, we: t.fl || (base != 0), stall: 1'b1, addr: 5'(base), data: w1};
      q.push_back(e);
      e = '{hasPort: 1'b1, isFp: t.fl, we: 1'b1, stall: 1'b0, addr: 5'(base + 1), data: w2};
      q.push_back(e);
    end
  endtask

  function automatic instr_t rnd();
    instr_t t;
    t.wr  = ($urandom_range(0, 3) != 0);
    t.fl  = 1'($urandom_range(0, 1));
    t.dw  = ($urandom_range(0, 2) == 0);
    t.src = 2'($urandom_range(0, 3));
    t.a1 = $urandom; t.a2 = $urandom; t.m1 = $urandom; t.m2 = $urandom;
    t.pc = $urandom; t.im = $urandom;
    t.dst = 5'($urandom_range(0, 31));
    return t;
  endfunction

  function automatic instr_t mk(input logic wr, input logic fl, input logic [1:0] src,
                                input logic dw, input logic [4:0] dst);
    instr_t t;
    t = rnd();
    t.wr = wr; t.fl = fl; t.src = src; t.dw = dw; t.dst = dst;
    return t;
  endfunction

  task automatic drive(input instr_t t);
    iWrite = t.wr; iFloat = t.fl; iWBsrc = t.src; iDW = t.dw;
    iALUout1 = t.a1; iALUout2 = t.a2; iMemOut1 = t.m1; iMemOut2 = t.m2;
    iPcp4 = t.pc; iIm = t.im; iDstReg = t.dst;
  endtask

  // Issue one instruction; during the DW stall cycle the inputs carry junk that must be ignored.
  task automatic issue(input instr_t t);
    drive(t);
    @(posedge clk);
    model(t);
    if (t.wr && t.dw) begin
      #1 drive(rnd());
      @(posedge clk);
    end
    #1 iWrite = 1'b0;
  endtask

  always @(negedge clk) begin
    if (monOn && rst_n) begin
      if (q.size() == 0) begin
        check("idle_intWe", 32'(oIntWe), 32'd0);
        check("idle_fpWe", 32'(oFpWe), 32'd0);
        check("idle_stall", 32'(oStall), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("intWe", 32'(oIntWe), 32'(e.hasPort && !e.isFp && e.we));
        check("fpWe", 32'(oFpWe), 32'(e.hasPort && e.isFp && e.we));
        check("stall", 32'(oStall), 32'(e.stall));
        if (e.hasPort && e.isFp) begin
          check("fpAddr", 32'(oFpAddr), 32'(e.addr));
          check("fpData", oFpData, e.data);
        end else if (e.hasPort) begin
          check("intAddr", 32'(oIntAddr), 32'(e.addr));
          check("intData", oIntData, e.data);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_intWe"}, 32'(oIntWe), 32'd0);
    check({tag, "_fpWe"}, 32'(oFpWe), 32'd0);
    check({tag, "_stall"}, 32'(oStall), 32'd0);
    check({tag, "_intAddr"}, 32'(oIntAddr), 32'd0);
    check({tag, "_fpAddr"}, 32'(oFpAddr), 32'd0);
    check({tag, "_intData"}, oIntData, 32'd0);
    check({tag, "_fpData"}, oFpData, 32'd0);
  endtask

  initial begin
    instr_t t;
    #12 check_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 monOn = 1'b1;

    issue(mk(1'b0, 1'b0, 2'd0, 1'b0, 5'd3));
    t = mk(1'b1, 1'b0, 2'd1, 1'b0, 5'd8); t.m1 = 32'hDEADBEEF; issue(t);
    t = mk(1'b1, 1'b0, 2'd2, 1'b0, 5'd0); t.pc = 32'h404; issue(t);
    t = mk(1'b1, 1'b0, 2'd2, 1'b0, 5'd31); t.pc = 32'h404; issue(t);
    t = mk(1'b1, 1'b1, 2'd1, 1'b1, 5'd5); t.m1 = 32'h11111111; t.m2 = 32'h22222222; issue(t);
    issue(mk(1'b1, 1'b0, 2'd0, 1'b0, 5'd3));
    issue(mk(1'b1, 1'b1, 2'd0, 1'b1, 5'd2));
    issue(mk(1'b1, 1'b1, 2'd0, 1'b1, 5'd6));
    issue(mk(1'b1, 1'b0, 2'd0, 1'b1, 5'd1));
    issue(mk(1'b1, 1'b0, 2'd3, 1'b1, 5'd12));
    issue(mk(1'b1, 1'b1, 2'd0, 1'b0, 5'd0));
    issue(mk(1'b1, 1'b0, 2'd3, 1'b0, 5'd17));

    for (int i = 0; i < 400; i++) issue(rnd());

    // Reset asserted while the odd half of an FP pair is pending.
    repeat (2) @(posedge clk);
    #1 monOn = 1'b0;
    t = mk(1'b1, 1'b1, 2'd1, 1'b1, 5'd9);
    drive(t);
    @(posedge clk);
    #3;
    check("sec_stall", 32'(oStall), 32'd1);
    check("sec_fpWe", 32'(oFpWe), 32'd1);
    check("sec_fpAddr", 32'(oFpAddr), 32'd8);
    check("sec_fpData", oFpData, t.m1);
    rst_n = 1'b0;
    #1 check_zero("midrst");
    iWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_fpWe", 32'(oFpWe), 32'd0);
    check("post_stall", 32'(oStall), 32'd0);
    check("post_fpAddr", 32'(oFpAddr), 32'd0);
    monOn = 1'b1;
    t = mk(1'b1, 1'b0, 2'd0, 1'b0, 5'd4);
    issue(t);
    for (int i = 0; i < 50; i++) issue(rnd());

    repeat (4) @(posedge clk);
    check("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Consumer end of the MEM/WB pipeline register: takes the latched MEM/WB bundle and commits it to the integer and FP register files.
- Selects writeback data by WBsrc.
- Splits double-word (DW) results into two single-port register-file writes over two cycles, stalling upstream for the second.
- Sits between the MEM/WB register outputs and the write ports of the integer and FP register files.

Parameters:
- DATA_W, 32, register data width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iWrite  in  1  MEM/WB: instruction writes a register.
- iFloat  in  1  MEM/WB: destination is the FP file (0 = integer file).
- iWBsrc  in  2  MEM/WB: writeback source select.
- iDW  in  1  MEM/WB: double-word result (register pair).
- iALUout1, iALUout2  in  DATA_W each  MEM/WB: ALU result low/high word.
- iMemOut1, iMemOut2  in  DATA_W each  MEM/WB: memory read low/high word.
- iPcp4  in  DATA_W  MEM/WB: PC+4 (link value).
- iIm  in  DATA_W  MEM/WB: extended immediate.
- iDstReg  in  REG_AW  MEM/WB: destination register.
- oIntWe  out  1  integer register-file write enable.
- oIntAddr  out  REG_AW  integer write address.
- oIntData  out  DATA_W  integer write data.
- oFpWe  out  1  FP register-file write enable.
- oFpAddr  out  REG_AW  FP write address.
- oFpData  out  DATA_W  FP write data.
- oStall  out  1  hold MEM/WB and all earlier stages this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; oIntWe, oFpWe, oIntAddr, oFpAddr, oIntData, oFpData, oStall all 0. Outputs are held while rst_n is low.
- All write-port outputs are registered: an instruction sampled at edge N drives the write port during cycle N..N+1. The register file captures it at edge N+1, so the commit latency is 1 cycle.
- Source select, first word: WBsrc 0 = ALUout1, 1 = MemOut1, 2 = Pcp4, 3 = Im.
- Source select, second (DW) word: MemOut2 if WBsrc=1, else ALUout2. DW with WBsrc 2 or 3 is illegal: the second word is ALUout2 and no error is flagged.
- File select: iFloat=1 targets the FP port, iFloat=0 targets the integer port. Exactly one port's We is ever high in a cycle.
- Integer register 0 is never written: the We for address 0 is forced 0. Address and data still update. FP register 0 is writable.
- State IDLE, per rising edge:
  - iWrite=0: both We go to 0; stay IDLE.
  - iWrite=1, iDW=0: drive the selected port with addr=iDstReg and data=word1; stay IDLE.
  - iWrite=1, iDW=1: drive addr={iDstReg[REG_AW-1:1],0} with word1. Latch word2, addr {iDstReg[REG_AW-1:1],1} and the file select into internal registers; go to SECOND.
- State SECOND:
  - oStall=1 combinationally for the whole cycle. Upstream freezes MEM/WB, so its outputs hold the next instruction unchanged.
  - All inputs are ignored.
  - At the edge, drive the latched odd address/word2 on the latched port; return to IDLE.
- oStall=0 in IDLE. Exactly one stall cycle per DW instruction. Back-to-back DW instructions give the pattern: stall, no stall, stall.
- iDstReg[0] is ignored when iDW=1, which enforces even-aligned pairs.
- Integer DW to r0/r1: the r0 write is suppressed, the r1 write proceeds.
- Reset asserted in SECOND: the second write is lost, the state goes to IDLE, and oStall drops immediately.
- Data width is unaltered: no sign extension and no arithmetic in this block.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 asynchronously. Release with iWrite=0 -> oIntWe=oFpWe=0, oStall=0.
- Integer load: iWrite=1, iFloat=0, iWBsrc=1, iMemOut1=0xDEADBEEF, iDstReg=8 -> next cycle oIntWe=1, oIntAddr=8, oIntData=0xDEADBEEF, oFpWe=0.
- Integer write to r0 (iWBsrc=2, iPcp4=0x404, iDstReg=0) -> oIntWe=0. Then jal-style link to r31 -> oIntWe=1, addr 31, data 0x404.
- FP DW load: iFloat=1, iDW=1, iWBsrc=1, iDstReg=5, MemOut1=0x11111111, MemOut2=0x22222222:
  - cycle1: oFpAddr=4, data 0x11111111, oStall=1.
  - cycle2: oFpAddr=5, data 0x22222222, oStall=0.
  - The held following instruction commits in cycle3.
- Back-to-back DW ALU ops (iWBsrc=0) to f2 then f6 -> writes f2, f3, f6, f7 on consecutive cycles. oStall pattern is 1, 0, 1, 0; ALUout2 is used for the odd registers.
- rst_n pulsed low during SECOND -> oStall=0 and oFpWe=0 at once. No odd-register write after release; state is IDLE.
